// File: rtl/flag_rf_stack_if.sv
// rtl/flag_rf_stack_if.sv - flag write, condition, push/pop and stack status bundle for flag_rf_stack.
interface flag_rf_stack_if #(
  parameter int NUM_BANKS   = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = $clog2(STACK_DEPTH + 1);

  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic              z;
  logic              v;
  logic              n;
  logic [BANK_W-1:0] rd_bank;
  logic [3:0]        cond;
  logic              out;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output wr_en, wr_bank, z, v, n, rd_bank, cond, push, pop, clr_err,
    input  out, stack_cnt, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  wr_en, wr_bank, z, v, n, rd_bank, cond, push, pop, clr_err,
    output out, stack_cnt, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flag_rf_stack.sv
// rtl/flag_rf_stack.sv - banked Z/V/N flag register file with branch-condition decode and save/restore stack.
// Optional same-cycle write-to-condition forwarding under macro FLAG_BYPASS_EN.
module flag_rf_stack #(
  parameter int NUM_BANKS   = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  flag_rf_stack_if.slave  bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = $clog2(STACK_DEPTH + 1);

  // Flag triple packing is {z, v, n}.
  logic [NUM_BANKS-1:0][2:0]   bank_q, bank_d;
  logic [STACK_DEPTH-1:0][2:0] stack_q, stack_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic [2:0] rd_flags;
  logic [2:0] eval_flags;
  logic [2:0] top_flags;
  logic       full;
  logic       empty;
  logic       do_push;
  logic       do_pop;
  logic       err_ev;
  logic       cond_out;
  logic       unused_cond;

  assign unused_cond = bus.cond[3];
  assign full        = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty       = (cnt_q == '0);

  // Out-of-range bank indices match no entry and read as 000.
  always_comb begin
    rd_flags = 3'b000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bus.rd_bank == BANK_W'(i)) rd_flags = bank_q[i];
    end
  end

  always_comb begin
    top_flags = 3'b000;
    for (int j = 0; j < STACK_DEPTH; j++) begin
      if (cnt_q == CNT_W'(j + 1)) top_flags = stack_q[j];
    end
  end

`ifdef FLAG_BYPASS_EN
  always_comb begin
    eval_flags = rd_flags;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bus.wr_en && bus.wr_bank == BANK_W'(i) && bus.rd_bank == BANK_W'(i))
        eval_flags = {bus.z, bus.v, bus.n};
    end
  end
`else
  assign eval_flags = rd_flags;
`endif

  always_comb begin
    cond_out = 1'b0;
    case (bus.cond[2:0])
      3'b000:  cond_out = eval_flags[2];
      3'b001:  cond_out = eval_flags[0] & ~eval_flags[1];
      3'b010:  cond_out = ~eval_flags[2] & ~eval_flags[1] & ~eval_flags[0];
      3'b011:  cond_out = eval_flags[1];
      3'b100:  cond_out = ~eval_flags[2];
      3'b101:  cond_out = ~eval_flags[0] & ~eval_flags[1];
      3'b110:  cond_out = (eval_flags[0] & ~eval_flags[1]) | eval_flags[2];
      default: cond_out = 1'b1;
    endcase
  end

  assign do_push = bus.push & ~bus.pop & ~full;
  assign do_pop  = bus.pop & ~bus.push & ~empty;
  assign err_ev  = (bus.push & bus.pop) | (bus.push & ~bus.pop & full) |
                   (bus.pop & ~bus.push & empty);

  // The pop restore is applied after the write so it overrides a same-bank write.
  always_comb begin
    bank_d  = bank_q;
    stack_d = stack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.wr_en) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (bus.wr_bank == BANK_W'(i)) bank_d[i] = {bus.z, bus.v, bus.n};
      end
    end
    if (do_push) begin
      for (int j = 0; j < STACK_DEPTH; j++) begin
        if (cnt_q == CNT_W'(j)) stack_d[j] = rd_flags;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (do_pop) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (bus.rd_bank == BANK_W'(i)) bank_d[i] = top_flags;
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (err_ev) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q  <= '0;
      stack_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      stack_q <= stack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.out         = cond_out;
  assign bus.stack_cnt   = cnt_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_flag_rf_stack.sv
// tb/tb_flag_rf_stack.sv - scoreboard bench for flag_rf_stack with directed vectors.
module tb_flag_rf_stack;
`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string tag;
    logic  exp_out;
    int    exp_cnt;
    logic  exp_err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sample_req;
  logic final_req;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];
  exp_t mon_e;

  flag_rf_stack_if #(.NUM_BANKS(4), .STACK_DEPTH(4)) bus ();

  flag_rf_stack #(.NUM_BANKS(4), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic eo, input int ec, input logic ee);
    exp_t e;
    e.tag     = tag;
    e.exp_out = eo;
    e.exp_cnt = ec;
    e.exp_err = ee;
    sb_q.push_back(e);
    sample_req = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample_req  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic wr(input logic [1:0] b, input logic zz, input logic vv, input logic nn);
    bus.wr_en   = 1'b1;
    bus.wr_bank = b;
    bus.z       = zz;
    bus.v       = vv;
    bus.n       = nn;
  endtask

  always @(negedge clk) begin
    if (sample_req) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: DUT sampled with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.out !== mon_e.exp_out || bus.stack_cnt !== 3'(mon_e.exp_cnt) ||
            bus.stack_full !== (mon_e.exp_cnt == 4) || bus.stack_empty !== (mon_e.exp_cnt == 0) ||
            bus.stack_err !== mon_e.exp_err) begin
          n_bad++;
          $display("FAIL %s: got out=%0b cnt=%0d full=%0b empty=%0b err=%0b, expected out=%0b cnt=%0d full=%0b empty=%0b err=%0b",
                   mon_e.tag, bus.out, bus.stack_cnt, bus.stack_full, bus.stack_empty, bus.stack_err,
                   mon_e.exp_out, mon_e.exp_cnt, mon_e.exp_cnt == 4, mon_e.exp_cnt == 0, mon_e.exp_err);
        end
      end
    end
    if (final_req) begin
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_bad++;
        $display("FAIL sb_drain: got %0d expectations left, expected 0", sb_q.size());
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    sample_req  = 1'b0;
    final_req   = 1'b0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_bank = 2'd0;
    bus.z       = 1'b0;
    bus.v       = 1'b0;
    bus.n       = 1'b0;
    bus.rd_bank = 2'd0;
    bus.cond    = 4'b0000;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    @(posedge clk);
    #1;

    bus.cond = 4'b0010; chk("rst_gt", 1'b1, 0, 1'b0); tick();
    bus.cond = 4'b0000; chk("rst_eq", 1'b0, 0, 1'b0); tick();
    bus.cond = 4'b1100; chk("rst_ne_bit3", 1'b1, 0, 1'b0); tick();
    rst_n = 1'b1;
    bus.cond = 4'b0101; chk("ge_init", 1'b1, 0, 1'b0); tick();

    bus.rd_bank = 2'd2; bus.cond = 4'b0000; wr(2'd2, 1'b1, 1'b0, 1'b0);
    chk("eq_wr_cycle", BYP, 0, 1'b0); tick();
    chk("eq_bank2", 1'b1, 0, 1'b0); tick();
    bus.cond = 4'b0110; chk("le_bank2", 1'b1, 0, 1'b0); tick();
    bus.cond = 4'b0100; chk("ne_bank2", 1'b0, 0, 1'b0); tick();
    bus.cond = 4'b0010; chk("gt_bank2", 1'b0, 0, 1'b0); tick();
    bus.rd_bank = 2'd1; chk("gt_bank1", 1'b1, 0, 1'b0); tick();

    bus.rd_bank = 2'd0; wr(2'd0, 1'b0, 1'b0, 1'b1); tick();
    bus.push = 1'b1; bus.cond = 4'b0001; chk("lt_push", 1'b1, 0, 1'b0); tick();
    wr(2'd0, 1'b0, 1'b1, 1'b0); bus.cond = 4'b0011; chk("ov_wr_cycle", BYP, 1, 1'b0); tick();
    bus.pop = 1'b1; chk("ov_pre_pop", 1'b1, 1, 1'b0); tick();
    bus.cond = 4'b0001; chk("lt_restored", 1'b1, 0, 1'b0); tick();
    bus.cond = 4'b0011; chk("ov_restored", 1'b0, 0, 1'b0); tick();

    bus.cond = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1; chk("push_fill", 1'b1, i, 1'b0); tick();
    end
    bus.push = 1'b1; chk("push_when_full", 1'b1, 4, 1'b0); tick();
    chk("overflow_err", 1'b1, 4, 1'b1); tick();
    bus.clr_err = 1'b1; chk("clr_pre", 1'b1, 4, 1'b1); tick();
    chk("clr_done", 1'b1, 4, 1'b0); tick();
    for (int i = 4; i > 0; i--) begin
      bus.pop = 1'b1; chk("pop_drain", 1'b1, i, 1'b0); tick();
    end
    bus.pop = 1'b1; chk("pop_when_empty", 1'b1, 0, 1'b0); tick();
    chk("underflow_err", 1'b1, 0, 1'b1); tick();
    bus.push = 1'b1; bus.pop = 1'b1; bus.clr_err = 1'b1;
    chk("push_pop_conflict", 1'b1, 0, 1'b1); tick();
    chk("err_beats_clr", 1'b1, 0, 1'b1); tick();
    bus.clr_err = 1'b1; chk("clr2_pre", 1'b1, 0, 1'b1); tick();

    bus.rd_bank = 2'd3; bus.cond = 4'b0000; wr(2'd3, 1'b1, 1'b0, 1'b0);
    chk("b3_wr_cycle", BYP, 0, 1'b0); tick();
    bus.push = 1'b1; chk("b3_push", 1'b1, 0, 1'b0); tick();
    bus.pop = 1'b1; wr(2'd3, 1'b0, 1'b0, 1'b1);
    chk("pop_vs_wr_cycle", !BYP, 1, 1'b0); tick();
    chk("pop_wins_eq", 1'b1, 0, 1'b0); tick();
    bus.cond = 4'b0001; chk("pop_wins_lt", 1'b0, 0, 1'b0); tick();
    bus.push = 1'b1; chk("b3_push2", 1'b0, 0, 1'b0); tick();
    bus.pop = 1'b1; wr(2'd1, 1'b0, 1'b1, 1'b0);
    chk("pop_other_wr", 1'b0, 1, 1'b0); tick();
    bus.rd_bank = 2'd1; bus.cond = 4'b0011; chk("other_wr_kept", 1'b1, 0, 1'b0); tick();

    bus.rd_bank = 2'd2; bus.cond = 4'b0000; bus.push = 1'b1;
    chk("pre_reset", 1'b1, 0, 1'b0); tick();
    bus.push = 1'b1; rst_n = 1'b0; bus.cond = 4'b0010;
    chk("reset_mid", 1'b1, 0, 1'b0); tick();
    rst_n = 1'b1;
    bus.cond = 4'b0000; chk("post_reset_eq", 1'b0, 0, 1'b0); tick();
    bus.rd_bank = 2'd3; chk("post_reset_b3", 1'b0, 0, 1'b0); tick();

    final_req = 1'b1;
    @(negedge clk);
    #1;
    final_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flag_rf_stack.md
Name: flag_rf_stack

Overview:
- Next-generation condition-flag register file.
- Holds NUM_BANKS independent Z/V/N flag sets, one per execution context.
- Evaluates the 8 branch conditions against a selected bank.
- Adds a save/restore stack of depth STACK_DEPTH so interrupt/call entry can push a bank's flags and exit can pop them back. Sits between the ALU flag outputs and branch/predication logic.

Parameters:
- NUM_BANKS, 4, number of flag banks (>=1).
- STACK_DEPTH, 4, entries in the flag save stack (>=1).
- BANK_W, $clog2(NUM_BANKS) (min 1), width of bank select ports.
- CNT_W, $clog2(STACK_DEPTH+1), width of stack occupancy count.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write z/v/n into bank wr_bank this edge.
- wr_bank  in  BANK_W  destination bank for flag write.
- z  in  1  zero flag from ALU.
- v  in  1  overflow flag from ALU.
- n  in  1  negative flag from ALU.
- rd_bank  in  BANK_W  bank used for condition evaluation, push source and pop destination.
- cond  in  4  condition code; bit 3 ignored.
- out  out  1  condition result.
- push  in  1  save rd_bank flags onto stack.
- pop  in  1  restore stack top into rd_bank.
- clr_err  in  1  clear sticky stack_err.
- stack_cnt  out  CNT_W  current stack occupancy.
- stack_full  out  1  stack_cnt == STACK_DEPTH.
- stack_empty  out  1  stack_cnt == 0.
- stack_err  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (async, rst_n low):
  - All bank flags = 3'b000.
  - Stack entries = 0; stack_cnt = 0.
  - stack_empty = 1, stack_full = 0, stack_err = 0.
  - out follows combinationally: cond 3'b111 -> 1; cond 3'b010 -> 1 (all flags 0); other codes -> 0 except NE/GE -> 1.
- Flag write:
  - On edge with wr_en = 1, bank[wr_bank] <= {z,v,n}.
  - Visible to out one cycle later (registered path).
- Condition decode (cond[2:0], combinational from bank[rd_bank]):
  - 000 EQ: Z.
  - 001 LT: N & ~V.
  - 010 GT: ~Z & ~V & ~N.
  - 011 OV: V.
  - 100 NE: ~Z.
  - 101 GE: ~N & ~V.
  - 110 LE: (N & ~V) | Z.
  - 111 TRUE: 1.
  - out is fully combinational; no latch inferred; every code is defined.
- Push (push = 1, pop = 0, not full):
  - stack[stack_cnt] <= bank[rd_bank] (pre-edge value); stack_cnt + 1.
  - A simultaneous wr_en to the same bank still applies. The stack captures the OLD value.
- Pop (pop = 1, push = 0, not empty):
  - bank[rd_bank] <= stack[stack_cnt-1]; stack_cnt - 1.
  - If wr_en targets the same bank in the same cycle, pop wins and the write is dropped.
  - A write to a different bank proceeds.
- Error cases (stack_err <= 1; stack and banks unchanged except the unrelated wr_en):
  - Push when full.
  - Pop when empty.
  - Push and pop in the same cycle.
- stack_err is sticky. clr_err clears it next edge. If clr_err coincides with a new error, the error wins (stays 1).
- No wrap-around: stack never overwrites or underflows.
- stack_full and stack_empty are decoded combinationally from stack_cnt.
- Out-of-range bank index (NUM_BANKS not a power of 2):
  - Writes ignored; reads return 3'b000 flags.
  - Push of an out-of-range bank pushes 000.
  - Pop into an out-of-range bank discards the entry but decrements.
- Reset asserted mid-push/pop: async clear wins; no partial update.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: when wr_en = 1 and wr_bank == rd_bank, out is evaluated from the incoming z/v/n in the same cycle (zero-latency forwarding). Push is unaffected and still captures the registered value.
- Undefined: out always reads the registered bank (1-cycle write-to-use latency).

Test Plan:
- Reset then cond = 4'b0010 -> out = 1. cond = 4'b0000 -> out = 0. stack_empty = 1, stack_cnt = 0.
- Write bank 2 with {z,v,n} = 1,0,0, rd_bank = 2 -> next cycle EQ = 1, LE = 1, NE = 0, GT = 0. Bank 1 still gives GT = 1. With FLAG_BYPASS_EN, EQ = 1 in the write cycle itself.
- Write bank 0 = {0,0,1}; push; write bank 0 = {0,1,0}; pop -> bank 0 back to {0,0,1}: LT = 1, OV = 0; stack_cnt 0 -> 1 -> 0.
- Push 4 times (DEPTH = 4) -> stack_full = 1. Fifth push -> stack_err = 1, stack_cnt stays 4. clr_err -> stack_err = 0.
- Pop on empty stack -> stack_err = 1, banks unchanged. Then push and pop together -> stack_err stays 1, stack_cnt unchanged.
- Pop with wr_en to the same bank in the same cycle -> bank takes the popped value, not the written one. Assert rst_n low mid-sequence -> all flags 000 and stack_cnt 0 immediately.
